// File: rtl/traffic_pkg.sv
// traffic_pkg: shared FSM state encoding and lamp codes for the intersection controller.
package traffic_pkg;

  // Controller states; code 2'b11 is unused and treated as illegal.
  typedef enum logic [1:0] {
    ALL_RED = 2'b00,
    GREEN   = 2'b01,
    YELLOW  = 2'b10
  } state_t;

  // Per-phase lamp triplet {R,Y,G}, always one-hot.
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

endpackage

// File: rtl/traffic_phase_arbiter.sv
// traffic_phase_arbiter: combinational round-robin picker for the next GREEN phase.
// Searches from the phase after cur_idx; the current phase itself is the last candidate.
// With no demand anywhere it falls back to plain rotation (cur_idx + 1).
module traffic_phase_arbiter #(
  parameter int NUM_PHASES = 4,
  localparam int PH_W      = $clog2(NUM_PHASES)
) (
  input  logic [NUM_PHASES-1:0] demand,
  input  logic [PH_W-1:0]       cur_idx,
  output logic [PH_W-1:0]       next_idx
);

  int              cand;
  logic            found;
  logic [PH_W-1:0] cand_idx;

  // Walk the ring starting one past the current owner and keep the first requester.
  always_comb begin
    cand = int'(cur_idx) + 1;
    if (cand >= NUM_PHASES) cand = cand - NUM_PHASES;
    next_idx = PH_W'(cand);
    found    = 1'b0;
    cand_idx = '0;
    for (int off = 1; off <= NUM_PHASES; off++) begin
      cand = int'(cur_idx) + off;
      if (cand >= NUM_PHASES) cand = cand - NUM_PHASES;
      cand_idx = PH_W'(cand);
      if (!found && demand[cand_idx]) begin
        found    = 1'b1;
        next_idx = cand_idx;
      end
    end
  end

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// traffic_intersection_ctrl: multi-phase intersection controller.
// One phase at a time runs GREEN->YELLOW and every handover passes through ALL_RED.
// Dwell timing advances only on tick_en strobes; vehicle demand lets idle phases be skipped.
// Optional pedestrian WALK support is compiled in by defining PED_WALK_EN.
module traffic_intersection_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_PHASES   = 4,
  parameter int CNT_W        = 8,
  parameter int GREEN_TICKS  = 5,
  parameter int YELLOW_TICKS = 3,
  parameter int ALLRED_TICKS = 1,
  localparam int PH_W        = $clog2(NUM_PHASES)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    tick_en,
  input  logic [NUM_PHASES-1:0]   veh_req,
  output logic [3*NUM_PHASES-1:0] lights,
  output logic [PH_W-1:0]         active_phase,
  output logic [1:0]              state_o,
  output logic                    phase_start
`ifdef PED_WALK_EN
  ,
  input  logic [NUM_PHASES-1:0]   ped_req,
  output logic [NUM_PHASES-1:0]   walk
`endif
);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      dur_m1;
  logic [PH_W-1:0]       active_q, active_d;
  logic [PH_W-1:0]       next_phase;
  logic [NUM_PHASES-1:0] dem_q, dem_d;
  logic [NUM_PHASES-1:0] demand_all;
  logic [NUM_PHASES-1:0] entry_mask;
  logic                  start_q;
  logic                  enter_green;
  logic                  enter_yellow;

  traffic_phase_arbiter #(
    .NUM_PHASES (NUM_PHASES)
  ) u_arbiter (
    .demand   (demand_all),
    .cur_idx  (active_q),
    .next_idx (next_phase)
  );

  // State register, dwell counter, demand latches and the GREEN-entry pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ALL_RED;
      cnt_q    <= '0;
      active_q <= PH_W'(NUM_PHASES - 1);
      dem_q    <= '0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      dem_q    <= dem_d;
      start_q  <= enter_green;
    end
  end

  // Dwell length of the current state, expressed as the final counter value.
  always_comb begin
    dur_m1 = '0;
    case (state_q)
      ALL_RED: dur_m1 = CNT_W'(ALLRED_TICKS - 1);
      GREEN:   dur_m1 = CNT_W'(GREEN_TICKS - 1);
      YELLOW:  dur_m1 = CNT_W'(YELLOW_TICKS - 1);
      default: dur_m1 = '0;
    endcase
  end

  // Next-state logic: advance on a tick, transition when the dwell expires.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    active_d     = active_q;
    enter_green  = 1'b0;
    enter_yellow = 1'b0;
    case (state_q)
      ALL_RED, GREEN, YELLOW: begin
        if (tick_en) begin
          if (cnt_q == dur_m1) begin
            cnt_d = '0;
            case (state_q)
              ALL_RED: begin
                state_d     = GREEN;
                active_d    = next_phase;
                enter_green = 1'b1;
              end
              GREEN: begin
                state_d      = YELLOW;
                enter_yellow = 1'b1;
              end
              default: state_d = ALL_RED;
            endcase
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ALL_RED;
        cnt_d   = '0;
      end
    endcase
  end

  // Demand latches collect requests; the phase entering GREEN has its latch cleared (clear wins).
  always_comb begin
    entry_mask = '0;
    for (int p = 0; p < NUM_PHASES; p++) begin
      entry_mask[p] = enter_green && (next_phase == PH_W'(p));
    end
    dem_d = (dem_q | veh_req) & ~entry_mask;
  end

`ifdef PED_WALK_EN
  logic [NUM_PHASES-1:0] ped_q, ped_d;
  logic [NUM_PHASES-1:0] walk_q, walk_d;

  // Pedestrian latches and WALK lamps, cleared together with the vehicle state on reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ped_q  <= '0;
      walk_q <= '0;
    end else begin
      ped_q  <= ped_d;
      walk_q <= walk_d;
    end
  end

  // WALK is granted on GREEN entry of a phase with a pending push and held until GREEN ends.
  always_comb begin
    ped_d  = (ped_q | ped_req) & ~entry_mask;
    walk_d = '0;
    if (state_d == GREEN) begin
      walk_d = enter_green ? (entry_mask & ped_q) : walk_q;
    end
  end

  assign demand_all = dem_q | ped_q;
  assign walk       = walk_q;
`else
  assign demand_all = dem_q;
`endif

  // Lamp decode: only the owning phase may show green or yellow; illegal states show all red.
  always_comb begin
    lights = {NUM_PHASES{LAMP_RED}};
    for (int p = 0; p < NUM_PHASES; p++) begin
      if (active_q == PH_W'(p)) begin
        case (state_q)
          GREEN:   lights[3*p +: 3] = LAMP_GRN;
          YELLOW:  lights[3*p +: 3] = LAMP_YEL;
          default: lights[3*p +: 3] = LAMP_RED;
        endcase
      end
    end
  end

  assign active_phase = active_q;
  assign state_o      = state_q;
  assign phase_start  = start_q;

endmodule
